// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-port arbiter and sequencer for a single-cycle data memory.
// Port 0 is the core load/store unit and port 1 is the loader/debug master.
// Every accepted request runs as a fixed three-cycle transaction:
//   IDLE   : grant (combinational gnt), capture the request, classify it
//   ACCESS : drive the memory pins (only for a legal, aligned address)
//   RESP   : one-cycle rvalid pulse with rdata/err on the granted port
// Misaligned or out-of-range requests never touch the memory and complete
// with err=1 and rdata=0.
//
// Ports
//   clk, reset               clock (rising edge), async active-high reset
//   rN_req/we/addr/wdata     request from port N, held until rN_gnt is seen
//   rN_gnt                   request accepted this cycle (combinational)
//   rN_rvalid/rdata/err      registered one-cycle completion pulse
//   mem_addr/wdata           byte address and write data to the memory
//   mem_write/mem_read       memory enables, high only during ACCESS
//   mem_rdata                memory read data (combinational from mem_addr)
//
// gnt depends only on registered state and the req inputs; every other
// output is a flop, so there is no combinational path from mem_rdata to
// any output.
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,

  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;

  // Round-robin pointer: 0 favours port 0 on a simultaneous request.
  logic prio;

  // Transaction context captured at grant time.
  logic lat_port;   // 0 = port 0, 1 = port 1
  logic lat_we;
  logic lat_bad;

  // Selected request (valid only when one of the gnt outputs is high).
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [ADDR_W-1:0] sel_word;
  logic              sel_bad;

  // Read data returned with the response: memory data for a good read,
  // zero for writes and for rejected requests.
  logic [DATA_W-1:0] resp_data;

  // ---------------------------------------------------------------------------
  // Grant logic. Grants are issued only in IDLE; a requester that loses
  // simply keeps req high and is picked up on the next IDLE cycle, where the
  // flipped priority pointer guarantees it wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the block leaves it unassigned (which would infer a latch).
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (state == IDLE) begin
      if (r0_req && (!r1_req || !prio)) begin
        r0_gnt = 1'b1;
      end else if (r1_req) begin
        r1_gnt = 1'b1;
      end
    end
  end

  // Request mux and address classification for the granted port.
  always_comb begin
    sel_port  = r1_gnt;
    sel_we    = sel_port ? r1_we    : r0_we;
    sel_addr  = sel_port ? r1_addr  : r0_addr;
    sel_wdata = sel_port ? r1_wdata : r0_wdata;
    sel_word  = sel_addr >> 2;
    sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_word >= ADDR_W'(MEM_WORDS));
  end

  assign resp_data = (!lat_bad && !lat_we) ? mem_rdata : '0;

  // ---------------------------------------------------------------------------
  // Sequencer. The mem_* outputs are registered: they are loaded on the edge
  // entering ACCESS and cleared on the edge leaving it, so they are nonzero
  // exactly for the ACCESS cycle. The response outputs follow the same
  // pattern one cycle later for RESP.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      lat_port  <= 1'b0;
      lat_we    <= 1'b0;
      lat_bad   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      r0_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r0_err    <= 1'b0;
      r1_rvalid <= 1'b0;
      r1_rdata  <= '0;
      r1_err    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the values from before this edge regardless of order.
      unique case (state)
        IDLE: begin
          if (r0_gnt || r1_gnt) begin
            lat_port <= sel_port;
            lat_we   <= sel_we;
            lat_bad  <= sel_bad;
            prio     <= !sel_port;
            // A rejected request leaves the memory pins at zero.
            if (!sel_bad) begin
              mem_addr  <= sel_addr;
              mem_wdata <= sel_wdata;
              mem_write <= sel_we;
              mem_read  <= !sel_we;
            end
            state <= ACCESS;
          end
        end

        ACCESS: begin
          // The memory commits a write, and its read data is captured, on
          // the edge that ends this cycle.
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_write <= 1'b0;
          mem_read  <= 1'b0;
          r0_rvalid <= !lat_port;
          r1_rvalid <= lat_port;
          r0_rdata  <= lat_port ? '0 : resp_data;
          r1_rdata  <= lat_port ? resp_data : '0;
          r0_err    <= !lat_port && lat_bad;
          r1_err    <= lat_port && lat_bad;
          state     <= RESP;
        end

        RESP: begin
          r0_rvalid <= 1'b0;
          r0_rdata  <= '0;
          r0_err    <= 1'b0;
          r1_rvalid <= 1'b0;
          r1_rdata  <= '0;
          r1_err    <= 1'b0;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
